// File: rtl/rock_driver.sv
// Rocking-motion driver: phase accumulator sets swing rate, PWM sets motor drive strength.
// Optional soft start (amplitude ramps up after reset) is enabled by defining ROCK_DRIVER_SOFTSTART_EN.
module rock_driver #(
  parameter int ACC_W     = 16,
  parameter int FREQ_INIT = 64,
  parameter int FREQ_MIN  = 16,
  parameter int FREQ_MAX  = 240,
  parameter int FREQ_STEP = 8,
  parameter int AMP_INIT  = 128,
  parameter int AMP_MIN   = 32,
  parameter int AMP_MAX   = 255,
  parameter int AMP_STEP  = 16,
  parameter int RECOVER   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       Fplus,
  input  logic       Fmin,
  input  logic       Amin,
  output logic       dir,
  output logic       pwm,
  output logic [7:0] freq,
  output logic [7:0] amp,
  output logic       swing_done,
  output logic       sat
);

  localparam int CNT_W = $clog2(RECOVER + 1);
  localparam logic [7:0] L_FINIT = 8'(FREQ_INIT);
  localparam logic [7:0] L_FMIN  = 8'(FREQ_MIN);
  localparam logic [7:0] L_FMAX  = 8'(FREQ_MAX);
  localparam logic [7:0] L_FSTEP = 8'(FREQ_STEP);
  localparam logic [7:0] L_AINIT = 8'(AMP_INIT);
  localparam logic [7:0] L_AMIN  = 8'(AMP_MIN);
  localparam logic [7:0] L_AMAX  = 8'(AMP_MAX);
  localparam logic [7:0] L_ASTEP = 8'(AMP_STEP);
  localparam logic [CNT_W-1:0] L_RLAST = CNT_W'(RECOVER - 1);

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] lim);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] lim);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (d[8] || (d[7:0] < lim)) ? lim : d[7:0];
  endfunction

  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_freq, r_amp, r_pwm_cnt;
  logic [CNT_W-1:0] r_clean;
  logic             r_swing_done, r_pend_fp, r_pend_fm, r_pend_am, r_soft_done;
  logic [ACC_W:0]   w_sum;
  logic [7:0]       w_freq_nxt, w_amp_nxt;
  logic [CNT_W-1:0] w_clean_nxt;

  assign w_sum = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, r_freq};

  always_comb begin
    w_freq_nxt  = r_freq;
    w_amp_nxt   = r_amp;
    w_clean_nxt = r_clean;
    if (r_swing_done) begin
      if (r_pend_fp && !r_pend_fm)      w_freq_nxt = sat_add(r_freq, L_FSTEP, L_FMAX);
      else if (r_pend_fm && !r_pend_fp) w_freq_nxt = sat_sub(r_freq, L_FSTEP, L_FMIN);
      if (!r_soft_done) begin
        // Ramp phase: amplitude requests and recovery are deliberately ignored.
        w_amp_nxt   = sat_add(r_amp, L_ASTEP, L_AINIT);
        w_clean_nxt = '0;
      end else if (r_pend_am) begin
        w_amp_nxt   = sat_sub(r_amp, L_ASTEP, L_AMIN);
        w_clean_nxt = '0;
      end else if (r_clean == L_RLAST) begin
        w_amp_nxt   = sat_add(r_amp, 8'd1, L_AMAX);
        w_clean_nxt = '0;
      end else begin
        w_clean_nxt = r_clean + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_pwm_cnt    <= '0;
      r_swing_done <= 1'b0;
      r_pend_fp    <= 1'b0;
      r_pend_fm    <= 1'b0;
      r_pend_am    <= 1'b0;
      r_clean      <= '0;
      r_freq       <= L_FINIT;
`ifdef ROCK_DRIVER_SOFTSTART_EN
      r_amp        <= L_AMIN;
      r_soft_done  <= 1'b0;
`else
      r_amp        <= L_AINIT;
      r_soft_done  <= 1'b1;
`endif
    end else begin
      r_pwm_cnt    <= r_pwm_cnt + 1'b1;
      if (enable) r_acc <= w_sum[ACC_W-1:0];
      r_swing_done <= enable & w_sum[ACC_W];
      // Requests seen on the swing_done clk survive the clear and wait for the next swing.
      r_pend_fp    <= (r_pend_fp & ~r_swing_done) | Fplus;
      r_pend_fm    <= (r_pend_fm & ~r_swing_done) | Fmin;
      r_pend_am    <= (r_pend_am & ~r_swing_done) | Amin;
      r_freq       <= w_freq_nxt;
      r_amp        <= w_amp_nxt;
      r_clean      <= w_clean_nxt;
      r_soft_done  <= r_soft_done | (w_amp_nxt == L_AINIT);
    end
  end

  assign dir        = r_acc[ACC_W-1];
  assign pwm        = enable & (r_pwm_cnt < r_amp);
  assign freq       = r_freq;
  assign amp        = r_amp;
  assign swing_done = r_swing_done;
  assign sat        = (r_freq == L_FMIN) | (r_freq == L_FMAX) |
                      (r_amp == L_AMIN) | (r_amp == L_AMAX);

endmodule

// File: tb/tb_rock_driver.sv
// Bench for rock_driver: directed scenarios plus random stimulus against a behavioural model.
module tb_rock_driver;
  localparam int MOD = 65536;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b1, Fplus = 1'b0, Fmin = 1'b0, Amin = 1'b0;
  logic dir, pwm, swing_done, sat;
  logic [7:0] freq, amp;

  rock_driver dut (
    .clk(clk), .reset(reset), .enable(enable), .Fplus(Fplus), .Fmin(Fmin), .Amin(Amin),
    .dir(dir), .pwm(pwm), .freq(freq), .amp(amp), .swing_done(swing_done), .sat(sat)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: whole-number arithmetic on settings, swing boundary flagged by overflow.
  int m_acc = 0, m_freq = 64, m_amp = 128, m_cnt = 0, m_clean = 0;
  bit m_sd = 0, m_pfp = 0, m_pfm = 0, m_pam = 0, m_ramped = 1;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  task automatic model_step(input bit rst, input bit en, input bit fp, input bit fm, input bit am);
    int f_old;
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_clean = 0; m_sd = 0;
      m_pfp = 0; m_pfm = 0; m_pam = 0; m_freq = 64;
`ifdef ROCK_DRIVER_SOFTSTART_EN
      m_amp = 32; m_ramped = 0;
`else
      m_amp = 128; m_ramped = 1;
`endif
      return;
    end
    f_old = m_freq;
    if (m_sd) begin
      if (m_pfp && !m_pfm) m_freq = imin(m_freq + 8, 240);
      if (m_pfm && !m_pfp) m_freq = imax(m_freq - 8, 16);
      if (!m_ramped) begin
        m_amp = imin(m_amp + 16, 128);
        m_clean = 0;
        if (m_amp == 128) m_ramped = 1;
      end else if (m_pam) begin
        m_amp = imax(m_amp - 16, 32);
        m_clean = 0;
      end else begin
        m_clean++;
        if (m_clean == 4) begin
          m_amp = imin(m_amp + 1, 255);
          m_clean = 0;
        end
      end
      m_pfp = 0; m_pfm = 0; m_pam = 0;
    end
    m_pfp |= fp; m_pfm |= fm; m_pam |= am;
    if (en) begin
      m_sd  = (m_acc + f_old) >= MOD;
      m_acc = (m_acc + f_old) % MOD;
    end else begin
      m_sd = 0;
    end
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic cyc();
    logic [19:0] exp;
    bit e_sat;
    @(posedge clk);
    model_step(reset, enable, Fplus, Fmin, Amin);
    #1;
    e_sat = (m_freq == 16) || (m_freq == 240) || (m_amp == 32) || (m_amp == 255);
    exp = {(m_acc >= MOD / 2), (enable && (m_cnt < m_amp)), m_sd, e_sat, 8'(m_freq), 8'(m_amp)};
    chk("outputs", {12'd0, dir, pwm, swing_done, sat, freq, amp}, {12'd0, exp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to_sd(input int bound);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!m_sd && k < bound);
    if (!m_sd) chk("sd_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; Fplus = 0; Fmin = 0; Amin = 0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int n, sdc, pwc;
    bit d0;
    reset = 1'b1;
    run(3);
    chk("rst_freq", freq, 64);
    chk("rst_dir", dir, 0);
    chk("rst_sd", swing_done, 0);
    reset = 1'b0;

`ifdef ROCK_DRIVER_SOFTSTART_EN
    chk("soft_rst_amp", amp, 32);
    Amin = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      run_to_sd(2000); cyc();
      chk("soft_ramp", amp, 32 + 16 * k);
    end
    run_to_sd(2000); cyc();
    chk("soft_amin_after", amp, 112);
    do_reset();
`else
    chk("rst_amp", amp, 128);
`endif

    // Nominal swing timing from reset release
    n = 0;
    do begin
      cyc();
      n++;
      if (n == 511) chk("dir_511", dir, 0);
      if (n == 512) chk("dir_512", dir, 1);
    end while (!swing_done && n < 2000);
    chk("first_sd_clk", n, 1024);

    // Single Fplus pulse mid-swing
    run(300);
    Fplus = 1; cyc(); Fplus = 0;
    run_to_sd(2000);
    chk("freq_hold", freq, 64);
    n = 0;
    do begin
      cyc();
      n++;
      if (n == 1) chk("freq_72", freq, 72);
    end while (!swing_done && n < 2000);
    chk("period_72", n, 1 + (MOD - 64 + 71) / 72);

    // Opposing requests cancel
    run(100);
    Fplus = 1; cyc(); Fplus = 0;
    run(50);
    Fmin = 1; cyc(); Fmin = 0;
    run_to_sd(2000); cyc();
    chk("freq_cancel", freq, 72);

    // Fplus held for 30 swings saturates
    Fplus = 1;
    for (int k = 0; k < 30; k++) run_to_sd(5000);
    cyc();
    Fplus = 0;
    chk("freq_sat", freq, 240);
    chk("sat_flag", sat, 1);

    // Amin each swing, then recovery
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      Amin = 1; cyc(); Amin = 0;
      run_to_sd(2000); cyc();
`ifndef ROCK_DRIVER_SOFTSTART_EN
      chk("amp_dec", amp, (128 - 16 * k < 32) ? 32 : 128 - 16 * k);
`endif
    end
`ifndef ROCK_DRIVER_SOFTSTART_EN
    chk("amp_floor_sat", sat, 1);
`endif
    for (int k = 1; k <= 4; k++) begin
      run_to_sd(2000); cyc();
`ifndef ROCK_DRIVER_SOFTSTART_EN
      chk("amp_recover", amp, (k == 4) ? 33 : 32);
`endif
    end

    // Reset discards pending request
    run(200);
    Fplus = 1; cyc(); Fplus = 0;
    reset = 1; Fplus = 1; cyc(); Fplus = 0; reset = 0;
    run_to_sd(2000); cyc();
    chk("rst_discard", freq, 64);

    // Enable low freezes motion
    run(300);
    d0 = dir;
    enable = 0; sdc = 0; pwc = 0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      sdc += swing_done; pwc += pwm;
    end
    chk("dis_sd", sdc, 0);
    chk("dis_pwm", pwc, 0);
    chk("dis_dir", dir, d0);
    enable = 1;

    // Random phase
    for (int i = 0; i < 25000; i++) begin
      reset  = ($urandom_range(0, 5999) == 0);
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      Fplus  = ($urandom_range(0, 299) == 0);
      Fmin   = ($urandom_range(0, 399) == 0);
      Amin   = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
